regfile_multiport: RTL and testbench

//   Parametrised register file: one write port and NREAD independent read ports.

---
 rtl/regfile_multiport.sv | 90 +++++++++
 tb/tb_regfile_multiport.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Purpose : NREAD-port register file with one write port, zero register and write-to-read forwarding.
// Latency : READ_REG=1 -> read data one clk after rd_en; READ_REG=0 -> combinational.
// Backpr. : none; every port accepts a read each cycle and the write port never stalls.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset; clears storage and read outputs
//   wr_en     write strobe; wr_addr/wr_data sampled on the rising clk
//   wr_addr   write register index (AW bits)
//   wr_data   write data (WIDTH bits)
//   rd_en     per-port read request
//   rd_addr   per-port read index
//   rd_data   per-port read data
//   rd_valid  per-port read data valid
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NREAD-1:0]            rd_en,
  input  logic [NREAD-1:0][AW-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_valid
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ZADDR   = AW'(DEPTH - 1);

  logic [WIDTH-1:0]            mem [DEPTH];
  logic                        wr_ok;
  logic [NREAD-1:0][WIDTH-1:0] rd_value;

  // Index is backed by real, writable storage (in range and not the zero register).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == ZADDR));
  endfunction

  assign wr_ok = wr_en && addr_live(wr_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Forwarding needs only wr_en: the read side already forces 0 for
  // indices that a write could never land on.
  always_comb begin
    rd_value = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (addr_live(rd_addr[p])) begin
        if (wr_en && (wr_addr == rd_addr[p])) rd_value[p] = wr_data;
        else                                  rd_value[p] = mem[rd_addr[p]];
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_data  <= '0;
          rd_valid <= '0;
        end else begin
          for (int p = 0; p < NREAD; p++) begin
            if (rd_en[p]) rd_data[p] <= rd_value[p];
          end
          rd_valid <= rd_en;
        end
      end
    end else begin : g_rd_comb
      // Gated by reset so both variants present zeros while reset is held,
      // even if wr_data is being forwarded.
      assign rd_data  = reset_n ? rd_value : '0;
      assign rd_valid = reset_n ? rd_en    : '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Purpose : directed checks of regfile_multiport across four configurations driven in lockstep.
// Latency : instances 0..2 registered (1 clk), instance 3 combinational.
// Backpr. : not applicable; stimulus is one vector per clk.
module tb_regfile_multiport;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [4:0]        wr_addr = '0;
  logic [63:0]       wr_data = '0;
  logic [1:0]        rd_en = '0;
  logic [1:0][4:0]   rd_addr = '0;
  logic [1:0][63:0]  rdd [4];
  logic [1:0]        rdv [4];

  logic [63:0]       shadow [32];
  logic [63:0]       hold [4][2];
  int                n_vec = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  // inst 0: defaults, 1: ZERO_REG=0, 2: DEPTH=20, 3: READ_REG=0
  regfile_multiport u_dflt (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0]));
  regfile_multiport #(.ZERO_REG(0)) u_nz (.clk(clk), .reset_n(reset_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdd[1]), .rd_valid(rdv[1]));
  regfile_multiport #(.DEPTH(20)) u_d20 (.clk(clk), .reset_n(reset_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdd[2]), .rd_valid(rdv[2]));
  regfile_multiport #(.READ_REG(0)) u_comb (.clk(clk), .reset_n(reset_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdd[3]), .rd_valid(rdv[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value for instance k at index a given the current write inputs.
  function automatic logic [63:0] expv(input int k, input logic [4:0] a);
    int depth = (k == 2) ? 20 : 32;
    bit zr    = (k != 1);
    if (int'(a) >= depth || (zr && int'(a) == depth - 1)) return 64'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return shadow[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) shadow[i] = 64'h0;
    for (int k = 0; k < 4; k++) begin
      hold[k][0] = 64'h0;
      hold[k][1] = 64'h0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s k%0d p%0d data", tag, k, p), rdd[k][p], 64'h0);
        chk($sformatf("%s k%0d p%0d valid", tag, k, p), {63'h0, rdv[k][p]}, 64'h0);
      end
  endtask

  // One clk with the currently driven inputs: comb instance checked before the
  // edge, registered instances checked #1 after it.
  task automatic cycle(input string tag);
    logic [1:0] en_q;
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s comb p%0d data a%0d", tag, p, rd_addr[p]), rdd[3][p], expv(3, rd_addr[p]));
      chk($sformatf("%s comb p%0d valid", tag, p), {63'h0, rdv[3][p]}, {63'h0, rd_en[p]});
    end
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++)
        if (rd_en[p]) hold[k][p] = expv(k, rd_addr[p]);
    en_q = rd_en;
    @(posedge clk);
    if (wr_en) shadow[wr_addr] = wr_data;
    #1;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s k%0d p%0d data", tag, k, p), rdd[k][p], hold[k][p]);
        chk($sformatf("%s k%0d p%0d valid", tag, k, p), {63'h0, rdv[k][p]}, {63'h0, en_q[p]});
      end
  endtask

  initial begin
    clear_model();
    // Reset held, reads requested: all outputs must stay 0.
    rd_en = 2'b11;
    #2 chk_zero("reset");
    @(posedge clk); #1;
    chk_zero("reset_edge");
    #2 reset_n = 1'b1;

    // 1: read every index on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i); rd_addr[1] = 5'(i); rd_en = 2'b11;
      cycle("t1_rd");
    end
    rd_en = 2'b00;
    cycle("t1_idle");

    // 2: pattern writes 0..30, then crossing sweeps.
    for (int i = 0; i < 31; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i);
      wr_data = (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h0;
      cycle("t2_wr");
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i); rd_addr[1] = 5'(31 - i); rd_en = 2'b11;
      cycle("t2_sweep");
    end

    // 3: write index 31 (zero register in defaults) with a same-cycle read, then plain read.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hDEADBEEF_CAFEF00D;
    rd_addr[0] = 5'd31; rd_addr[1] = 5'd31; rd_en = 2'b11;
    cycle("t3_wr31");
    wr_en = 1'b0;
    cycle("t3_rd31");

    // 4: forwarding on both ports, then the stored value without forwarding.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5; rd_en = 2'b11;
    cycle("t4_fwd");
    wr_en = 1'b0; rd_en = 2'b01;
    cycle("t4_rd5");
    rd_en = 2'b10; rd_addr[1] = 5'd4;
    cycle("t4_hold");

    // 5: index 25 is out of range for DEPTH=20; 0..18 must be untouched.
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 64'h77; rd_en = 2'b00;
    cycle("t5_wr25");
    wr_en = 1'b0;
    for (int i = 0; i < 19; i++) begin
      rd_addr[0] = 5'(i); rd_addr[1] = (i % 2 == 0) ? 5'd25 : 5'd19; rd_en = 2'b11;
      cycle("t5_sweep");
    end

    // 6: reset pulse away from the clk edge while a read of index 3 is active.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; rd_en = 2'b00;
    cycle("t6_wr3");
    wr_en = 1'b0; rd_addr[0] = 5'd3; rd_addr[1] = 5'd3; rd_en = 2'b11;
    cycle("t6_rd3");
    #2 reset_n = 1'b0;
    #1 chk_zero("t6_async");
    clear_model();
    #2 reset_n = 1'b1;
    cycle("t6_after");
    // Combinational port tracks the address with no clk edge in between.
    rd_addr[0] = 5'd2; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h0BAD_F00D;
    cycle("t6_comb");
    wr_en = 1'b0;
    cycle("t6_comb2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
